// File: rtl/formant_freq_sorter.sv
// Formant frequency sorter.
// Converts a frame of normalized formant angles to Hz with one shared
// multiplier, clamps each result to MAX_FREQ, sorts the frame ascending
// with odd-even transposition, and holds it on a valid/ready handshake.
module formant_freq_sorter #(
  parameter int BIT_WIDTH  = 32,
  parameter int FORMANTS   = 5,
  parameter int FREQ_WIDTH = 16,
  parameter int FS_HZ      = 10000,
  parameter int MAX_FREQ   = 5000
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [FORMANTS-1:0][BIT_WIDTH-1:0]   phi_in,
  input  logic                                 phi_valid_in,
  output logic [FORMANTS-1:0][FREQ_WIDTH-1:0]  freq_out,
  output logic [FORMANTS-1:0]                  clamp_out,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy_out,
  output logic                                 overrun_out
);

  localparam int IDX_W  = (FORMANTS > 1) ? $clog2(FORMANTS) : 1;
  localparam int PROD_W = BIT_WIDTH + FREQ_WIDTH;
  localparam logic [FREQ_WIDTH-1:0] HALF_FS = FREQ_WIDTH'(FS_HZ / 2);
  localparam logic [FREQ_WIDTH-1:0] MAX_F   = FREQ_WIDTH'(MAX_FREQ);
  localparam logic [IDX_W-1:0]      LAST    = IDX_W'(FORMANTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    SORT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                              state_q, state_d;
  logic [FORMANTS-1:0][BIT_WIDTH-1:0]  phi_q, phi_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [IDX_W-1:0]                    pass_q, pass_d;
  logic [FORMANTS-1:0][FREQ_WIDTH-1:0] work_q, work_d;
  logic [FORMANTS-1:0]                 wclamp_q, wclamp_d;
  logic [FORMANTS-1:0][FREQ_WIDTH-1:0] freq_q, freq_d;
  logic [FORMANTS-1:0]                 clamp_q, clamp_d;
  logic                                valid_q, valid_d;
  logic                                busy_q, busy_d;
  logic                                overrun_q, overrun_d;

  logic [PROD_W-1:0]                   prod;
  logic [FREQ_WIDTH-1:0]               f_scaled;
  logic                                f_over;
  logic [FORMANTS-1:0][FREQ_WIDTH-1:0] sorted_f;
  logic [FORMANTS-1:0]                 sorted_c;

  // Shared multiplier: scale the currently indexed angle to Hz and flag overflow of the ceiling
  always_comb begin
    prod     = PROD_W'(phi_q[idx_q]) * PROD_W'(HALF_FS);
    f_scaled = prod[PROD_W-1:BIT_WIDTH];
    f_over   = (f_scaled > MAX_F);
  end

  // One odd-even transposition pass; strict compare keeps equal values in order
  always_comb begin
    sorted_f = work_q;
    sorted_c = wclamp_q;
    for (int i = 0; i < FORMANTS - 1; i++) begin
      if ((i % 2) == int'(pass_q[0])) begin
        if (work_q[i] > work_q[i+1]) begin
          sorted_f[i]   = work_q[i+1];
          sorted_f[i+1] = work_q[i];
          sorted_c[i]   = wclamp_q[i+1];
          sorted_c[i+1] = wclamp_q[i];
        end
      end
    end
  end

  // Next-state logic for the frame FSM and all datapath registers
  always_comb begin
    state_d   = state_q;
    phi_d     = phi_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    work_d    = work_q;
    wclamp_d  = wclamp_q;
    freq_d    = freq_q;
    clamp_d   = clamp_q;
    valid_d   = valid_q;
    overrun_d = phi_valid_in && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (phi_valid_in) begin
          phi_d   = phi_in;
          idx_d   = '0;
          state_d = SCALE;
        end
      end
      SCALE: begin
        work_d[idx_q]   = f_over ? MAX_F : f_scaled;
        wclamp_d[idx_q] = f_over;
        if (idx_q == LAST) begin
          pass_d  = '0;
          state_d = SORT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SORT: begin
        work_d   = sorted_f;
        wclamp_d = sorted_c;
        if (pass_q == LAST) begin
          freq_d  = sorted_f;
          clamp_d = sorted_c;
          valid_d = 1'b1;
          state_d = OUT;
        end else begin
          pass_d = pass_q + IDX_W'(1);
        end
      end
      OUT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset discards any frame in flight
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      phi_q     <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      work_q    <= '0;
      wclamp_q  <= '0;
      freq_q    <= '0;
      clamp_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phi_q     <= phi_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      work_q    <= work_d;
      wclamp_q  <= wclamp_d;
      freq_q    <= freq_d;
      clamp_q   <= clamp_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign freq_out    = freq_q;
  assign clamp_out   = clamp_q;
  assign out_valid   = valid_q;
  assign busy_out    = busy_q;
  assign overrun_out = overrun_q;

endmodule

// File: tb/tb_formant_freq_sorter.sv
// Testbench for formant_freq_sorter.
// Three instances share stimulus: default ceiling, ceiling 4000 and ceiling 2500.
module tb_formant_freq_sorter;

  logic                 clk_in;
  logic                 rst_in;
  logic [4:0][31:0]     phi_in;
  logic                 phi_valid_in;
  logic                 out_ready;

  logic [4:0][15:0]     freq0, freq1, freq2;
  logic [4:0]           clamp0, clamp1, clamp2;
  logic                 valid0, valid1, valid2;
  logic                 busy0, busy1, busy2;
  logic                 ovr0, ovr1, ovr2;

  logic [4:0][15:0]     sel_freq;
  logic [4:0]           sel_clamp;
  logic                 sel_valid, sel_busy, sel_ovr;
  int                   cur_sel;

  int                   pass_count;
  int                   check_count;

  typedef struct {
    logic [31:0] phi [5];
    logic [15:0] exp_freq [5];
    logic [4:0]  exp_clamp;
    int          sel;
  } vec_t;

  vec_t vecs [7];

  formant_freq_sorter u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .phi_in(phi_in), .phi_valid_in(phi_valid_in),
    .freq_out(freq0), .clamp_out(clamp0), .out_valid(valid0), .out_ready(out_ready),
    .busy_out(busy0), .overrun_out(ovr0)
  );

  formant_freq_sorter #(.MAX_FREQ(4000)) u_dut_c4000 (
    .clk_in(clk_in), .rst_in(rst_in), .phi_in(phi_in), .phi_valid_in(phi_valid_in),
    .freq_out(freq1), .clamp_out(clamp1), .out_valid(valid1), .out_ready(out_ready),
    .busy_out(busy1), .overrun_out(ovr1)
  );

  formant_freq_sorter #(.MAX_FREQ(2500)) u_dut_c2500 (
    .clk_in(clk_in), .rst_in(rst_in), .phi_in(phi_in), .phi_valid_in(phi_valid_in),
    .freq_out(freq2), .clamp_out(clamp2), .out_valid(valid2), .out_ready(out_ready),
    .busy_out(busy2), .overrun_out(ovr2)
  );

  // Free-running clock, 10 time units per cycle
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Route the instance under test to a common set of observation signals
  always_comb begin
    case (cur_sel)
      1: begin
        sel_freq = freq1; sel_clamp = clamp1; sel_valid = valid1; sel_busy = busy1; sel_ovr = ovr1;
      end
      2: begin
        sel_freq = freq2; sel_clamp = clamp2; sel_valid = valid2; sel_busy = busy2; sel_ovr = ovr2;
      end
      default: begin
        sel_freq = freq0; sel_clamp = clamp0; sel_valid = valid0; sel_busy = busy0; sel_ovr = ovr0;
      end
    endcase
  end

  task automatic checkVal(input string name, input logic [79:0] act, input logic [79:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [79:0] packFreq(input vec_t v);
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[16*i +: 16] = v.exp_freq[i];
    return r;
  endfunction

  task automatic drivePhi(input vec_t v);
    for (int i = 0; i < 5; i++) phi_in[i] = v.phi[i];
    cur_sel      = v.sel;
    phi_valid_in = 1'b1;
  endtask

  // Present one frame for exactly one sampling edge; returns on the negedge after it
  task automatic applyStimulus(input vec_t v);
    @(negedge clk_in);
    drivePhi(v);
    @(negedge clk_in);
    phi_valid_in = 1'b0;
  endtask

  // Count edges after the sampling edge until out_valid, bounded
  task automatic waitValid(input string name);
    int lat;
    lat = 0;
    while (!sel_valid && lat < 40) begin
      @(negedge clk_in);
      lat++;
    end
    checkVal(name, 80'(lat), 80'(10));
  endtask

  task automatic checkOutput(input vec_t v, input string name);
    checkVal({name, " freq"}, 80'(sel_freq), packFreq(v));
    checkVal({name, " clamp"}, 80'(sel_clamp), 80'(v.exp_clamp));
  endtask

  initial begin
    bit stable_ok;
    bit quiet_ok;
    pass_count   = 0;
    check_count  = 0;
    cur_sel      = 0;
    rst_in       = 1'b0;
    phi_in       = '0;
    phi_valid_in = 1'b0;
    out_ready    = 1'b1;

    vecs[0].phi = '{32'h8000_0000, 32'h4000_0000, 32'hC000_0000, 32'h2000_0000, 32'h0};
    vecs[0].exp_freq = '{16'd0, 16'd625, 16'd1250, 16'd2500, 16'd3750};
    vecs[0].exp_clamp = 5'b00000; vecs[0].sel = 0;

    vecs[1].phi = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[1].exp_freq = '{16'd4999, 16'd4999, 16'd4999, 16'd4999, 16'd4999};
    vecs[1].exp_clamp = 5'b00000; vecs[1].sel = 0;

    vecs[2].phi = '{32'hF000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0, 32'hC000_0000};
    vecs[2].exp_freq = '{16'd0, 16'd625, 16'd1250, 16'd3750, 16'd4000};
    vecs[2].exp_clamp = 5'b10000; vecs[2].sel = 1;

    vecs[3].phi = vecs[2].phi;
    vecs[3].exp_freq = '{16'd0, 16'd625, 16'd1250, 16'd3750, 16'd4687};
    vecs[3].exp_clamp = 5'b00000; vecs[3].sel = 0;

    vecs[4].phi = '{32'hC000_0000, 32'h2000_0000, 32'h8000_0000, 32'h2000_0000, 32'h2000_0000};
    vecs[4].exp_freq = '{16'd625, 16'd625, 16'd625, 16'd2500, 16'd2500};
    vecs[4].exp_clamp = 5'b01000; vecs[4].sel = 2;

    vecs[5].phi = '{32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0};
    vecs[5].exp_freq = '{16'd0, 16'd625, 16'd1250, 16'd2500, 16'd3750};
    vecs[5].exp_clamp = 5'b00000; vecs[5].sel = 0;

    vecs[6].phi = vecs[1].phi;
    vecs[6].exp_freq = '{16'd4000, 16'd4000, 16'd4000, 16'd4000, 16'd4000};
    vecs[6].exp_clamp = 5'b11111; vecs[6].sel = 1;

    // Reset values
    #1;
    checkVal("reset freq", 80'(freq0), 80'(0));
    checkVal("reset clamp", 80'(clamp0), 80'(0));
    checkVal("reset valid", 80'(valid0), 80'(0));
    checkVal("reset busy", 80'(busy0), 80'(0));
    checkVal("reset overrun", 80'(ovr0), 80'(0));
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    // Table-driven frames with ready held high
    for (int n = 0; n < 7; n++) begin
      applyStimulus(vecs[n]);
      checkVal($sformatf("v%0d busy", n), 80'(sel_busy), 80'(1));
      waitValid($sformatf("v%0d latency", n));
      checkOutput(vecs[n], $sformatf("v%0d", n));
      @(negedge clk_in);
      checkVal($sformatf("v%0d valid pulse", n), 80'(sel_valid), 80'(0));
      checkVal($sformatf("v%0d idle", n), 80'(sel_busy), 80'(0));
    end

    // Backpressure: data held, mid-hold frame dropped with an overrun pulse
    out_ready = 1'b0;
    applyStimulus(vecs[0]);
    waitValid("hold latency");
    checkOutput(vecs[0], "hold first");
    stable_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_in);
      if (k == 6) checkVal("hold overrun pulse", 80'(sel_ovr), 80'(1));
      if (k == 7) checkVal("hold overrun clear", 80'(sel_ovr), 80'(0));
      if (k == 5) drivePhi(vecs[1]);
      if (k == 6) phi_valid_in = 1'b0;
      if (!sel_valid || (80'(sel_freq) !== packFreq(vecs[0])) || (sel_clamp !== 5'b0))
        stable_ok = 1'b0;
    end
    checkVal("hold stable", 80'(stable_ok), 80'(1));
    out_ready = 1'b1;
    @(negedge clk_in);
    checkVal("hold handshake valid", 80'(sel_valid), 80'(0));
    checkVal("hold handshake idle", 80'(sel_busy), 80'(0));
    checkVal("hold freq retained", 80'(sel_freq), packFreq(vecs[0]));

    // Reset during SORT clears everything; no stale frame appears afterwards
    applyStimulus(vecs[1]);
    repeat (7) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    checkVal("midreset freq", 80'(freq0), 80'(0));
    checkVal("midreset valid", 80'(valid0), 80'(0));
    checkVal("midreset busy", 80'(busy0), 80'(0));
    checkVal("midreset clamp", 80'(clamp0), 80'(0));
    @(negedge clk_in);
    rst_in = 1'b1;
    quiet_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_in);
      if (valid0 || busy0) quiet_ok = 1'b0;
    end
    checkVal("midreset discarded", 80'(quiet_ok), 80'(1));
    applyStimulus(vecs[5]);
    waitValid("postreset latency");
    checkOutput(vecs[5], "postreset");

    // Back-to-back: handshake-cycle frame dropped, next-cycle frame accepted
    @(negedge clk_in);
    applyStimulus(vecs[0]);
    waitValid("b2b latency");
    checkOutput(vecs[0], "b2b first");
    drivePhi(vecs[1]);
    @(negedge clk_in);
    checkVal("b2b drop overrun", 80'(sel_ovr), 80'(1));
    checkVal("b2b handshake", 80'(sel_valid), 80'(0));
    drivePhi(vecs[5]);
    @(negedge clk_in);
    phi_valid_in = 1'b0;
    checkVal("b2b accept no overrun", 80'(sel_ovr), 80'(0));
    checkVal("b2b accept busy", 80'(sel_busy), 80'(1));
    waitValid("b2b second latency");
    checkOutput(vecs[5], "b2b second");
    @(negedge clk_in);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
